// File: rtl/mac_rr_scheduler_if.sv
// Handshake bundle between the operand feeders / result collector and the
// round-robin MAC scheduler.
interface mac_rr_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_last;
    logic                      res_valid;
    logic                      res_ready;
    logic [ACC_W-1:0]          res_y;
    logic [ID_W-1:0]           res_id;
    logic                      res_overflow;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, req_last, res_ready,
        input  req_ready, res_valid, res_y, res_id, res_overflow, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_last, res_ready,
        output req_ready, res_valid, res_y, res_id, res_overflow, busy
    );

endinterface

// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler sharing one signed multiply/accumulate datapath
// between NUM_REQ burst requesters; returns the dot product tagged by id.
module mac_rr_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    mac_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BURST, FINAL, RESULT} state_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [DATA_W-1:0] b_q, b_d;
    logic                     pend_q, pend_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_q, ovf_d;
    logic [NUM_REQ-1:0]       ready_q, ready_d;
    logic                     res_valid_q, res_valid_d;
    logic                     busy_q, busy_d;

    logic                     found;
    logic [ID_W-1:0]          win;
    logic [NUM_REQ-1:0]       win_onehot;
    logic                     beat_fire;
    logic                     beat_last;
    logic signed [DATA_W-1:0] sel_a;
    logic signed [DATA_W-1:0] sel_b;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  sum;
    logic                     add_ovf;

    // Two passes give the rotating priority: indices above the pointer first,
    // then wrap around to the ones at or below it.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (ID_W'(i) > ptr_q)) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (ID_W'(i) <= ptr_q)) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (win == ID_W'(i));
        end
    end

    // ready_q is one-hot on the granted requester (or zero), so it doubles
    // as the operand select and the handshake qualifier.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        beat_fire = |(bus.req_valid & ready_q);
        beat_last = |(bus.req_valid & ready_q & bus.req_last);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready_q[i]) begin
                sel_a = bus.req_a[i*DATA_W +: DATA_W];
                sel_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign prod    = ACC_W'(a_q) * ACC_W'(b_q);
    assign sum     = acc_q + prod;
    assign add_ovf = (acc_q[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        pend_d      = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        ready_d     = ready_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;

        // Second pipeline stage: the beat captured last cycle is accumulated now.
        if (pend_q) begin
            acc_d = sum;
            if (add_ovf) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win;
                    ptr_d   = win;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    ready_d = win_onehot;
                    busy_d  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_fire) begin
                    a_d    = sel_a;
                    b_d    = sel_b;
                    pend_d = 1'b1;
                    if (beat_last) begin
                        ready_d = '0;
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            pend_q      <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            ready_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pend_q      <= pend_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_y        = acc_q;
    assign bus.res_id       = grant_q;
    assign bus.res_overflow = ovf_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed self-checking bench for mac_rr_scheduler with two requesters.
module tb_mac_rr_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mac_rr_scheduler_if #(.NUM_REQ(2), .ID_W(1), .DATA_W(8), .ACC_W(16)) bus ();

    mac_rr_scheduler #(.NUM_REQ(2), .ID_W(1), .DATA_W(8), .ACC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input int a, input int b,
                                 input logic last, input logic valid);
        bus.req_valid[req] = valid;
        bus.req_last[req]  = last;
        if (req == 1'b0) begin
            bus.req_a[7:0]  = 8'(a);
            bus.req_b[7:0]  = 8'(b);
        end else begin
            bus.req_a[15:8] = 8'(a);
            bus.req_b[15:8] = 8'(b);
        end
    endtask

    // Presents one beat and holds it until the handshake edge has passed.
    task automatic sendBeat(input logic req, input int a, input int b, input logic last);
        int n = 0;
        applyStimulus(req, a, b, last, 1'b1);
        while (bus.req_ready[req] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("beat_ready", 32'(bus.req_ready[req]), 1);
        tick();
        bus.req_valid[req] = 1'b0;
    endtask

    task automatic collectResult(input string tag, input int expY, input int expId,
                                 input logic expOvf);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(bus.res_valid), 1);
        checkOutput({tag, "_y"}, $signed(bus.res_y), expY);
        checkOutput({tag, "_id"}, 32'(bus.res_id), expId);
        checkOutput({tag, "_ovf"}, 32'(bus.res_overflow), 32'(expOvf));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checkOutput({tag, "_done"}, 32'(bus.res_valid), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.req_ready), 0);
        checkOutput({tag, "_valid"}, 32'(bus.res_valid), 0);
        checkOutput({tag, "_y"}, 32'(bus.res_y), 0);
        checkOutput({tag, "_id"}, 32'(bus.res_id), 0);
        checkOutput({tag, "_ovf"}, 32'(bus.res_overflow), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;

        // Back-to-back three-beat burst: 12 - 10 - 7 = -5
        sendBeat(1'b0, 3, 4, 1'b0);
        checkOutput("b2b_busy", 32'(bus.busy), 1);
        sendBeat(1'b0, -2, 5, 1'b0);
        sendBeat(1'b0, 7, -1, 1'b1);
        checkOutput("b2b_ready_drop", 32'(bus.req_ready), 0);
        checkOutput("b2b_valid_early", 32'(bus.res_valid), 0);
        tick();
        checkOutput("b2b_valid_rise", 32'(bus.res_valid), 1);
        collectResult("b2b", -5, 0, 1'b0);
        checkOutput("b2b_idle_busy", 32'(bus.busy), 0);

        // Both requesters continuously valid with single-beat bursts: ids alternate
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 2, 3, 1'b1, 1'b1);
        applyStimulus(1'b1, -4, 6, 1'b1, 1'b1);
        collectResult("rr0", 6, 0, 1'b0);
        collectResult("rr1", -24, 1, 1'b0);
        collectResult("rr2", 6, 0, 1'b0);
        collectResult("rr3", -24, 1, 1'b0);
        bus.req_valid = '0;

        // 3 x 16129 = 48387 wraps to -17149 with overflow on the third add
        sendBeat(1'b1, 127, 127, 1'b0);
        sendBeat(1'b1, 127, 127, 1'b0);
        sendBeat(1'b1, 127, 127, 1'b1);
        collectResult("ovf", -17149, 1, 1'b1);
        sendBeat(1'b1, 1, 1, 1'b1);
        collectResult("ovf_clear", 1, 1, 1'b0);

        // Stalled burst from req0 while req1 waits: 100 - 10 = 90
        applyStimulus(1'b1, 3, 3, 1'b1, 1'b1);
        sendBeat(1'b0, 10, 10, 1'b0);
        tick();
        checkOutput("stall_ready_a", 32'(bus.req_ready), 1);
        tick();
        checkOutput("stall_ready_b", 32'(bus.req_ready), 1);
        sendBeat(1'b0, -5, 2, 1'b1);
        checkOutput("stall_ready_done", 32'(bus.req_ready), 0);
        collectResult("stall", 90, 0, 1'b0);
        tick();
        checkOutput("late_grant", 32'(bus.req_ready), 2);
        sendBeat(1'b1, 3, 3, 1'b1);
        collectResult("late", 9, 1, 1'b0);

        // Result backpressure with new requests pending
        sendBeat(1'b0, 4, 5, 1'b1);
        tick();
        applyStimulus(1'b0, 9, 9, 1'b1, 1'b1);
        applyStimulus(1'b1, 9, 9, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", 32'(bus.res_valid), 1);
            checkOutput("bp_y", $signed(bus.res_y), 20);
            checkOutput("bp_id", 32'(bus.res_id), 0);
            checkOutput("bp_busy", 32'(bus.busy), 1);
            checkOutput("bp_ready", 32'(bus.req_ready), 0);
        end
        bus.req_valid = '0;
        collectResult("bp", 20, 0, 1'b0);

        // Reset in the middle of a req1 burst discards the partial sum
        sendBeat(1'b1, 5, 5, 1'b0);
        sendBeat(1'b1, 6, 6, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("midrst");
        applyStimulus(1'b1, 7, 7, 1'b1, 1'b1);
        sendBeat(1'b0, 1, 1, 1'b1);
        collectResult("rst0", 1, 0, 1'b0);
        sendBeat(1'b1, 7, 7, 1'b1);
        collectResult("rst1", 49, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
